// File: rtl/cru_ctrl_if.sv
// Bundles the TI CRU bus, the host bit-write handshake and the CRU register
// outputs of cru_ctrl; the controller sits on the slave side.
interface cru_ctrl_if;
    logic [0:3]  cru_base;
    logic        ti_cru_clk;
    logic        ti_memen;
    logic        ti_cru_out;
    logic [0:14] addr;
    logic        host_req;
    logic [1:0]  host_bit;
    logic        host_val;
    logic        host_gnt;
    logic [0:3]  bits;
    logic        pi_reset;
    logic        cru_in_oe;
    logic        cru_in_data;

    modport master (
        output cru_base, ti_cru_clk, ti_memen, ti_cru_out, addr,
        output host_req, host_bit, host_val,
        input  host_gnt, bits, pi_reset, cru_in_oe, cru_in_data
    );

    modport slave (
        input  cru_base, ti_cru_clk, ti_memen, ti_cru_out, addr,
        input  host_req, host_bit, host_val,
        output host_gnt, bits, pi_reset, cru_in_oe, cru_in_data
    );
endinterface

// File: rtl/cru_ctrl.sv
// CRU register block controller: synchronizes the TI CRU bus, decodes writes and
// reads, arbitrates TI/host bit writes and times the self-clearing Pi reset pulse.
module cru_ctrl #(
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned RST_PULSE_CYCLES = 16
) (
    input  logic      i_clk,
    input  logic      i_reset,
    cru_ctrl_if.slave cru
);
    localparam int unsigned CNT_W = $clog2(RST_PULSE_CYCLES + 1);

    typedef enum logic {
        ST_IDLE,
        ST_PULSE
    } state_t;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_memen_sync;
    logic [SYNC_STAGES-1:0] r_dout_sync;
    logic [0:14]            r_addr_sync [SYNC_STAGES];
    logic                   r_clk_prev;

    logic                   r_ti_wr;
    logic [1:0]             r_ti_idx;
    logic                   r_ti_val;

    logic [0:3]             r_bits;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_oe;
    logic                   r_rd;

    logic                   w_clk_s;
    logic                   w_memen_s;
    logic                   w_dout_s;
    logic [0:14]            w_addr_s;
    logic                   w_match;
    logic                   w_fall;
    logic                   w_host_gnt;
    logic                   w_wr_en;
    logic [1:0]             w_wr_idx;
    logic                   w_wr_val;
    logic [CNT_W-1:0]       w_cnt_dec;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [0:3]             w_bits_nxt;

    assign w_clk_s   = r_clk_sync[SYNC_STAGES-1];
    assign w_memen_s = r_memen_sync[SYNC_STAGES-1];
    assign w_dout_s  = r_dout_sync[SYNC_STAGES-1];
    assign w_addr_s  = r_addr_sync[SYNC_STAGES-1];

    assign w_match = (w_addr_s[0:3] == 4'b0001) && (w_addr_s[4:7] == cru.cru_base)
                     && (w_addr_s[8:14] < 7'd4);
    assign w_fall  = r_clk_prev && !w_clk_s;

    // The clock chain resets high so no falling edge is seen coming out of reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clk_sync   <= '1;
            r_memen_sync <= '0;
            r_dout_sync  <= '0;
            r_clk_prev   <= 1'b1;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) r_addr_sync[i] <= '0;
        end else begin
            r_clk_sync     <= {r_clk_sync[SYNC_STAGES-2:0], cru.ti_cru_clk};
            r_memen_sync   <= {r_memen_sync[SYNC_STAGES-2:0], cru.ti_memen};
            r_dout_sync    <= {r_dout_sync[SYNC_STAGES-2:0], cru.ti_cru_out};
            r_addr_sync[0] <= cru.addr;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) r_addr_sync[i] <= r_addr_sync[i-1];
            r_clk_prev     <= w_clk_s;
        end
    end

    // TI write strobe carries its own index/value so later address changes cannot leak in.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ti_wr  <= 1'b0;
            r_ti_idx <= '0;
            r_ti_val <= 1'b0;
            r_oe     <= 1'b0;
            r_rd     <= 1'b0;
        end else begin
            r_ti_wr  <= w_fall && w_match;
            r_ti_idx <= w_addr_s[13:14];
            r_ti_val <= w_dout_s;
            r_oe     <= w_memen_s && w_match;
            r_rd     <= (w_memen_s && w_match) ? r_bits[w_addr_s[13:14]] : 1'b0;
        end
    end

    assign w_host_gnt = cru.host_req && !r_ti_wr && !i_reset;
    assign w_wr_en    = r_ti_wr || cru.host_req;
    assign w_wr_idx   = r_ti_wr ? r_ti_idx : cru.host_bit;
    assign w_wr_val   = r_ti_wr ? r_ti_val : cru.host_val;
    assign w_cnt_dec  = r_cnt - 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bits_nxt  = r_bits;
        if (w_wr_en && (w_wr_idx != 2'd1)) w_bits_nxt[w_wr_idx] = w_wr_val;
        unique case (r_state)
            ST_IDLE: begin
                if (w_wr_en && (w_wr_idx == 2'd1)) begin
                    w_bits_nxt[1] = w_wr_val;
                    if (w_wr_val) begin
                        w_state_nxt = ST_PULSE;
                        w_cnt_nxt   = CNT_W'(RST_PULSE_CYCLES);
                    end
                end
            end
            ST_PULSE: begin
                // Writing 1 to bit 1 here is ignored; writing 0 aborts the pulse.
                if ((w_wr_en && (w_wr_idx == 2'd1) && !w_wr_val) || (w_cnt_dec == '0)) begin
                    w_state_nxt   = ST_IDLE;
                    w_cnt_nxt     = '0;
                    w_bits_nxt[1] = 1'b0;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bits  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bits  <= w_bits_nxt;
        end
    end

    assign cru.host_gnt    = w_host_gnt;
    assign cru.bits        = r_bits;
    assign cru.pi_reset    = (r_state == ST_PULSE);
    assign cru.cru_in_oe   = r_oe;
    assign cru.cru_in_data = r_rd;
endmodule

// File: tb/tb_cru_ctrl.sv
// Self-checking bench for cru_ctrl: directed scenarios followed by random TI/host
// traffic, all compared each cycle against a latency-based behavioural model.
module tb_cru_ctrl;
    localparam int S = 2;
    localparam int N = 16;
    localparam int HD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cru_ctrl_if bus ();

    cru_ctrl #(.SYNC_STAGES(S), .RST_PULSE_CYCLES(N)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .cru     (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Input samples seen at recent clock edges, index 0 = newest edge.
    int h_clk  [HD];
    int h_mem  [HD];
    int h_addr [HD];
    int h_dout [HD];

    int m_bits [4];
    int m_left;
    int obs_gnt;
    int pr_high;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int mk_addr(input int base, input int off);
        return (1 << 11) | (base << 7) | off;
    endfunction

    function automatic bit addr_match(input int a, input int base);
        return (((a >> 11) & 15) == 1) && (((a >> 7) & 15) == base) && ((a & 127) < 4);
    endfunction

    function automatic void clear_history();
        for (int i = 0; i < HD; i++) begin
            h_clk[i]  = 1;
            h_mem[i]  = 0;
            h_addr[i] = 0;
            h_dout[i] = 0;
        end
    endfunction

    // One clock: check the combinational grant mid-cycle, advance the model at the edge,
    // then check the registered outputs.
    task automatic tick();
        bit ti_due, wr, rst_now;
        int idx, val, rd_a, base, e_oe, e_data, e_bits;
        @(negedge clk);
        for (int i = HD - 1; i > 0; i--) begin
            h_clk[i]  = h_clk[i-1];
            h_mem[i]  = h_mem[i-1];
            h_addr[i] = h_addr[i-1];
            h_dout[i] = h_dout[i-1];
        end
        h_clk[0]  = int'(bus.ti_cru_clk);
        h_mem[0]  = int'(bus.ti_memen);
        h_addr[0] = int'(bus.addr);
        h_dout[0] = int'(bus.ti_cru_out);
        base    = int'(bus.cru_base);
        rst_now = rst;
        // A TI write lands S+1 edges after the first edge that saw the clock low.
        ti_due = !rst_now && (h_clk[S+1] == 0) && (h_clk[S+2] == 1) && addr_match(h_addr[S+1], base);
        check_eq("host_gnt", int'(bus.host_gnt), int'(!rst_now && bus.host_req && !ti_due));
        obs_gnt = int'(bus.host_gnt);
        rd_a   = h_addr[S];
        e_oe   = int'((h_mem[S] != 0) && addr_match(rd_a, base));
        e_data = (e_oe != 0) ? m_bits[rd_a & 3] : 0;
        wr  = ti_due || bus.host_req;
        idx = ti_due ? (h_addr[S+1] & 3) : int'(bus.host_bit);
        val = ti_due ? h_dout[S+1] : int'(bus.host_val);
        @(posedge clk);
        #1;
        if (rst_now) begin
            for (int i = 0; i < 4; i++) m_bits[i] = 0;
            m_left = 0;
            e_oe   = 0;
            e_data = 0;
            clear_history();
        end else if (m_left > 0) begin
            m_left--;
            if (wr && idx == 1 && val == 0) m_left = 0;
            if (m_left == 0) m_bits[1] = 0;
            if (wr && idx != 1) m_bits[idx] = val;
        end else begin
            if (wr) m_bits[idx] = val;
            if (wr && idx == 1 && val == 1) m_left = N;
        end
        e_bits = (m_bits[0] << 3) | (m_bits[1] << 2) | (m_bits[2] << 1) | m_bits[3];
        check_eq("bits", int'(bus.bits), e_bits);
        check_eq("pi_reset", int'(bus.pi_reset), int'(m_left > 0));
        check_eq("cru_in_oe", int'(bus.cru_in_oe), e_oe);
        check_eq("cru_in_data", int'(bus.cru_in_data), e_data);
        if (bus.pi_reset) pr_high++;
    endtask

    task automatic ti_write(input int idx, input int val, input int base_field);
        bus.addr       = 15'(mk_addr(base_field, idx));
        bus.ti_cru_out = val[0];
        bus.ti_memen   = 1'b0;
        bus.ti_cru_clk = 1'b1;
        tick();
        bus.ti_cru_clk = 1'b0;
        repeat (2) tick();
        bus.ti_cru_clk = 1'b1;
        repeat (4) tick();
    endtask

    task automatic host_write(input int idx, input int val);
        int got = 0;
        bus.host_req = 1'b1;
        bus.host_bit = 2'(idx);
        bus.host_val = val[0];
        for (int i = 0; i < 20 && got == 0; i++) begin
            tick();
            got = obs_gnt;
        end
        bus.host_req = 1'b0;
        check_eq("host_wait", got, 1);
    endtask

    initial begin
        int g0, g1, ph, r;
        clear_history();
        for (int i = 0; i < 4; i++) m_bits[i] = 0;
        m_left  = 0;
        pr_high = 0;
        bus.cru_base   = 4'h2;
        bus.ti_cru_clk = 1'b1;
        bus.ti_memen   = 1'b0;
        bus.ti_cru_out = 1'b0;
        bus.addr       = '0;
        bus.host_req   = 1'b0;
        bus.host_bit   = '0;
        bus.host_val   = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Matching TI write of 1 to bit 1 (also starts a pulse), then a base mismatch.
        ti_write(1, 1, 2);
        repeat (20) tick();
        bus.cru_base = 4'h3;
        repeat (2) tick();
        ti_write(0, 1, 2);
        bus.cru_base = 4'h2;
        repeat (2) tick();

        // Read back 1010.
        ti_write(0, 1, 2);
        ti_write(2, 1, 2);
        bus.ti_memen = 1'b1;
        bus.addr     = 15'(mk_addr(2, 2));
        repeat (4) tick();
        bus.addr = 15'(mk_addr(2, 4));
        repeat (4) tick();
        bus.addr = 15'(mk_addr(2, 0));
        repeat (4) tick();
        bus.ti_memen = 1'b0;

        // TI write to bit 0 and host write to bit 3 colliding in one cycle.
        ti_write(0, 0, 2);
        host_write(3, 0);
        bus.addr       = 15'(mk_addr(2, 0));
        bus.ti_cru_out = 1'b1;
        bus.ti_cru_clk = 1'b1;
        tick();
        bus.ti_cru_clk = 1'b0;
        repeat (2) tick();
        bus.ti_cru_clk = 1'b1;
        tick();
        bus.host_req = 1'b1;
        bus.host_bit = 2'd3;
        bus.host_val = 1'b1;
        tick();
        g0 = obs_gnt;
        tick();
        g1 = obs_gnt;
        bus.host_req = 1'b0;
        check_eq("arb_ti_first", g0, 0);
        check_eq("arb_host_next", g1, 1);
        repeat (3) tick();

        // Full pulse with an ignored re-trigger in the middle.
        pr_high = 0;
        host_write(1, 1);
        repeat (5) tick();
        ti_write(1, 1, 2);
        repeat (20) tick();
        check_eq("pulse_len", pr_high, N);

        // Abort by writing 0, then reset during a pulse.
        host_write(1, 1);
        ti_write(1, 0, 2);
        repeat (3) tick();
        host_write(1, 1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();

        // Random traffic.
        ph = 0;
        repeat (900) begin
            if (ph == 0) begin
                if (bus.ti_cru_clk) begin
                    bus.ti_cru_clk = 1'b0;
                end else begin
                    bus.ti_cru_clk = 1'b1;
                    r = int'($urandom_range(0, 3));
                    bus.addr = (r == 0) ? 15'($urandom_range(0, 32767))
                                        : 15'(mk_addr(2, int'($urandom_range(0, 5))));
                    bus.ti_cru_out = 1'($urandom_range(0, 1));
                    bus.ti_memen   = 1'($urandom_range(0, 1));
                end
                ph = int'($urandom_range(1, 4));
            end
            ph--;
            if (bus.host_req && obs_gnt != 0) begin
                bus.host_req = 1'($urandom_range(0, 1));
                bus.host_bit = 2'($urandom_range(0, 3));
                bus.host_val = 1'($urandom_range(0, 1));
            end else if (!bus.host_req && $urandom_range(0, 3) == 0) begin
                bus.host_req = 1'b1;
                bus.host_bit = 2'($urandom_range(0, 3));
                bus.host_val = 1'($urandom_range(0, 1));
            end
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        bus.host_req = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_err);
        $fatal(1);
    end
endmodule
